// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  // Saturating increment of a counter that is 'width' bits wide (1..32).
  // The counter is passed zero-extended to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    return (cnt == lim[31:0]) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Masked equality between the candidate history window and the stored pattern.
module seq_window_cmp #(
  parameter int SEQ_LEN = 4
) (
  input  logic [SEQ_LEN-1:0] window,
  input  logic [SEQ_LEN-1:0] pat,
  input  logic [SEQ_LEN-1:0] mask,
  output logic               eq
);

  // Cleared mask bits are don't-care positions.
  always_comb begin
    eq = (((window ^ pat) & mask) == '0);
  end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable Moore serial pattern detector with don't-care mask,
// overlap/non-overlap mode and a saturating match counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int SEQ_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               load,
  input  logic [SEQ_LEN-1:0] pat_in,
  input  logic [SEQ_LEN-1:0] mask_in,
  input  logic               ovl_in,
  input  logic               clr_cnt,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam int FW = $clog2(SEQ_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN);

  logic [SEQ_LEN-1:0] shreg, shreg_n;
  logic [FW-1:0]      fill, fill_n;
  logic [SEQ_LEN-1:0] pat_q, pat_n;
  logic [SEQ_LEN-1:0] mask_q, mask_n;
  logic               ovl_q, ovl_n;
  logic               match_q, match_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;

  logic [SEQ_LEN-1:0] sh_n;
  logic [FW-1:0]      fill_c;
  logic               win_eq;
  logic               hit;

  // Candidate window and saturated fill count if the current bit were accepted.
  always_comb begin
    sh_n   = {shreg[SEQ_LEN-2:0], x};
    fill_c = (fill == FULL) ? fill : fill + FW'(1);
  end

  seq_window_cmp #(
    .SEQ_LEN (SEQ_LEN)
  ) u_cmp (
    .window (sh_n),
    .pat    (pat_q),
    .mask   (mask_q),
    .eq     (win_eq)
  );

  // A hit needs a full window of bits accepted since the last restart.
  always_comb begin
    hit = (fill_c == FULL) && win_eq;
  end

  // Next-state selection: load restarts detection and beats an accepted bit;
  // a counter clear beats a simultaneous hit.
  always_comb begin
    shreg_n = shreg;
    fill_n  = fill;
    pat_n   = pat_q;
    mask_n  = mask_q;
    ovl_n   = ovl_q;
    match_n = 1'b0;
    cnt_n   = cnt_q;
    if (load) begin
      pat_n   = pat_in;
      mask_n  = mask_in;
      ovl_n   = ovl_in;
      shreg_n = '0;
      fill_n  = '0;
      cnt_n   = '0;
    end else if (x_valid) begin
      shreg_n = sh_n;
      match_n = hit;
      fill_n  = (hit && (ovl_q == MODE_NONOVL)) ? '0 : fill_c;
      if (hit) begin
        cnt_n = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      end
    end
    if (clr_cnt) begin
      cnt_n = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      fill    <= '0;
      pat_q   <= '0;
      mask_q  <= '1;
      ovl_q   <= MODE_OVL;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      shreg   <= shreg_n;
      fill    <= fill_n;
      pat_q   <= pat_n;
      mask_q  <= mask_n;
      ovl_q   <= ovl_n;
      match_q <= match_n;
      cnt_q   <= cnt_n;
    end
  end

  // Outputs are straight from state.
  always_comb begin
    y         = match_q;
    match_cnt = cnt_q;
    armed     = (fill == FULL);
  end

endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst, x, x_valid, load, clr_cnt, ovl_in;
  logic [L-1:0] pat_in, mask_in;
  logic y8, y2, armed8, armed2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  param_seq_detector #(.SEQ_LEN(L), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .load(load),
    .pat_in(pat_in), .mask_in(mask_in), .ovl_in(ovl_in), .clr_cnt(clr_cnt),
    .y(y8), .match_cnt(cnt8), .armed(armed8)
  );

  param_seq_detector #(.SEQ_LEN(L), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .load(load),
    .pat_in(pat_in), .mask_in(mask_in), .ovl_in(ovl_in), .clr_cnt(clr_cnt),
    .y(y2), .match_cnt(cnt2), .armed(armed2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       started = 0;
  bit       hist[$];
  int       fill_m = 0;
  bit       exp_y = 0;
  int       m_cnt8 = 0;
  int       m_cnt2 = 0;
  bit [L-1:0] m_pat = '0;
  bit [L-1:0] m_mask = '1;
  bit       m_ovl = 1;

  // Oldest of the last L accepted bits lines up with pattern bit L-1.
  function automatic bit window_matches();
    for (int i = 0; i < L; i++) begin
      if (m_mask[L-1-i] && (hist[i] != m_pat[L-1-i])) return 0;
    end
    return 1;
  endfunction

  always @(posedge clk) begin
    bit hit;
    started = 1;
    if (rst) begin
      hist.delete();
      fill_m = 0; exp_y = 0; m_cnt8 = 0; m_cnt2 = 0;
      m_pat = '0; m_mask = '1; m_ovl = 1;
    end else begin
      if (load) begin
        m_pat = pat_in; m_mask = mask_in; m_ovl = ovl_in;
        hist.delete();
        fill_m = 0; exp_y = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (x_valid) begin
        hist.push_back(x);
        if (hist.size() > L) void'(hist.pop_front());
        if (fill_m < L) fill_m++;
        hit = (fill_m == L) && window_matches();
        exp_y = hit;
        if (hit) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          if (!m_ovl) fill_m = 0;
        end
      end else begin
        exp_y = 0;
      end
      if (clr_cnt) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int pulses = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("y", int'(y8), int'(exp_y));
      chk("y_w2", int'(y2), int'(exp_y));
      chk("match_cnt", int'(cnt8), m_cnt8);
      chk("match_cnt_w2", int'(cnt2), m_cnt2);
      chk("armed", int'(armed8), int'(fill_m == L));
      chk("armed_w2", int'(armed2), int'(fill_m == L));
      if (y8) pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic ld, input logic xv,
                       input logic xb, input logic cl);
    rst = r; load = ld; x_valid = xv; x = xb; clr_cnt = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [L-1:0] p, input logic [L-1:0] m, input logic o);
    pat_in = p; mask_in = m; ovl_in = o;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    logic [15:0] vv;
    vv = v;
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, vv[i], 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int base;
  int exp5[8] = '{0, 0, 0, 1, 2, 3, 3, 3};

  initial begin
    pat_in = 4'b1010; mask_in = 4'b0000; ovl_in = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_y", int'(y8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    chk("rst_armed", int'(armed8), 0);

    // 1: overlapping 1001
    do_load(4'b1001, 4'b1111, 1'b1);
    base = pulses;
    bits(16'b1001001001, 10);
    idle();
    chk("t1_pulses", pulses - base, 3);
    chk("t1_cnt", int'(cnt8), 3);

    // 2: non-overlapping 1001
    do_load(4'b1001, 4'b1111, 1'b0);
    base = pulses;
    bits(16'b1001001001, 10);
    idle();
    chk("t2_pulses", pulses - base, 2);
    chk("t2_cnt", int'(cnt8), 2);

    // 3: masked pattern, bit 2 don't care
    do_load(4'b1101, 4'b1011, 1'b1);
    base = pulses;
    bits(16'b10011101, 8);
    chk("t3_last_y", int'(y8), 1);
    idle();
    chk("t3_pulses", pulses - base, 2);
    chk("t3_cnt", int'(cnt8), 2);

    // 4: gaps in x_valid
    do_load(4'b1001, 4'b1111, 1'b1);
    base = pulses;
    bits(16'b100, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_gap_y", int'(y8), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_gap_y", int'(y8), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_gap_y", int'(y8), 0);
    bits(16'b1, 1);
    chk("t4_hit_y", int'(y8), 1);
    idle();
    chk("t4_idle_y", int'(y8), 0);
    chk("t4_pulses", pulses - base, 1);

    // 5: all-don't-care mask, saturation on the 2-bit counter, clear beats hit
    do_load(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      bits(16'(i & 1), 1);
      chk("t5_cnt_w2", int'(cnt2), exp5[i]);
    end
    chk("t5_cnt8", int'(cnt8), 5);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_cnt", int'(cnt8), 0);
    chk("t5_clr_cnt_w2", int'(cnt2), 0);
    chk("t5_clr_y", int'(y8), 1);
    chk("t5_clr_armed", int'(armed8), 1);

    // 6: reset mid-stream, then load with x_valid high
    do_load(4'b1001, 4'b1111, 1'b1);
    bits(16'b100, 3);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    bits(16'b1, 1);
    chk("t6_rst_y", int'(y8), 0);
    chk("t6_rst_armed", int'(armed8), 0);
    do_load(4'b1001, 4'b1111, 1'b1);
    bits(16'b1001, 4);
    chk("t6_hit_cnt", int'(cnt8), 1);
    chk("t6_armed", int'(armed8), 1);
    pat_in = 4'b0110;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_load_armed", int'(armed8), 0);
    chk("t6_load_cnt", int'(cnt8), 0);
    chk("t6_load_y", int'(y8), 0);
    bits(16'b0110, 4);
    chk("t6_new_pat_y", int'(y8), 1);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Runtime-programmable, parametrised Moore serial-pattern detector. It is the generalised successor to the fixed 4-bit overlapping detector.
- Pattern, don't-care mask and overlap/non-overlap mode are programmable at runtime.
- Serial input is qualified by a valid strobe.
- A saturating match counter is provided.
- Sits between a serial bit source (deserialiser/line monitor) and control/status logic.

Parameters:
SEQ_LEN, 4, pattern length in bits (legal 2..32)
CNT_W, 8, width of saturating match counter (legal 1..32)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
x  in  1  serial data bit
x_valid  in  1  x sampled only on edges where high
load  in  1  one-cycle strobe: capture pat_in/mask_in/ovl_in, restart detection
pat_in  in  SEQ_LEN  pattern; bit SEQ_LEN-1 = first bit received, bit 0 = last
mask_in  in  SEQ_LEN  1 = compare this bit, 0 = don't care
ovl_in  in  1  1 = overlapping, 0 = non-overlapping
clr_cnt  in  1  synchronous clear of match_cnt
y  out  1  Moore match pulse (registered)
match_cnt  out  CNT_W  saturating count of matches
armed  out  1  fill counter has reached SEQ_LEN

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). All state updates on rising clk.
- State registers:
  - shreg[SEQ_LEN-1:0]: history window.
  - fill[$clog2(SEQ_LEN+1)-1:0]: bits accepted since restart.
  - pat_q, mask_q, ovl_q: configuration.
  - match_q: drives y.
  - cnt_q: drives match_cnt.
- Reset values: shreg=0, fill=0, match_q=0 (y=0), cnt_q=0 (match_cnt=0), armed=0, pat_q=0, mask_q=all ones, ovl_q=1.
- Priority, highest first: rst > load > x_valid.
- load edge:
  - Capture config; shreg=0, fill=0, match_q=0, cnt_q=0.
  - x is ignored on that edge even if x_valid=1.
- x_valid edge (no load):
  - sh_n = {shreg[SEQ_LEN-2:0], x}.
  - fill_c = min(fill+1, SEQ_LEN).
  - hit = (fill_c==SEQ_LEN) && (((sh_n ^ pat_q) & mask_q)==0).
  - Updates: shreg<=sh_n; match_q<=hit; fill<= (hit && !ovl_q) ? 0 : fill_c.
- Edge with x_valid=0 (no load): shreg and fill hold; match_q<=0. y is a one-cycle pulse per matching accepted bit.
- Latency: y high in the cycle immediately after the edge that samples the final pattern bit.
- Non-overlap semantics:
  - After a hit, SEQ_LEN fresh bits must be accepted before the next hit is possible.
  - shreg is not cleared; the window check resumes once fill saturates again.
- mask_q == 0: every accepted bit with fill saturated is a hit (overlap); every SEQ_LEN bits (non-overlap).
- armed = (fill==SEQ_LEN), combinational from state.
- Counter:
  - Increments on hit; saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt clears it.
  - clr_cnt and hit on the same edge: clear wins, result 0.
  - clr_cnt does not affect shreg, fill or y.
- rst mid-stream discards partial history; the first hit needs SEQ_LEN new accepted bits.

Decomposition:
- Package seq_det_pkg: localparams MODE_NONOVL=1'b0, MODE_OVL=1'b1; function sat_inc(cnt, width).
- One natural sub-module, seq_window_cmp: masked equality of sh_n vs pat_q, purely combinational. Everything else stays in top.

Test Plan:
1. SEQ_LEN=4, load pat=1001, mask=1111, ovl=1; x_valid=1, stream 1,0,0,1,0,0,1,0,0,1 → y pulses after bits 4, 7, 10; match_cnt=3.
2. Same stream, ovl=0 → y after bits 4 and 10 only; match_cnt=2.
3. pat=1101, mask=1011, ovl=1; stream 1,0,0,1,1,1,0,1 → hits after bit 4 (window 1001) and bit 8 (window 1101); match_cnt=2.
4. pat=1001, ovl=1; stream 1,0,0 with x_valid=1, then 3 cycles x_valid=0 (x toggling), then bit 1 → y stays 0 during gap; single pulse after the final bit; y=0 on the idle cycle that follows.
5. CNT_W=2, overlapping, mask=0000 after 4-bit fill → count 1,2,3,3,3 (saturates); clr_cnt asserted on an edge that also hits → match_cnt=0.
6. rst asserted after 3 bits of 1001, then 1 → no hit; load asserted with x_valid=1 mid-stream → fill=0, match_cnt=0, armed=0 the next cycle.
